// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: Decode/Execute hazard inputs and the stall/flush/forward controls.
interface hazard_ctrl_if;
    logic [2:0] dec_rs1;
    logic [2:0] dec_rs2;
    logic       dec_use1;
    logic       dec_use2;
    logic [2:0] ex_rs1;
    logic [2:0] ex_rs2;
    logic       ex_wr_en;
    logic [2:0] ex_wr_reg;
    logic [1:0] ex_ldst_en;
    logic       br_taken;
    logic       mem_ready;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       bubble_e;
    logic       flush_d;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_err;

    modport master (
        output dec_rs1, dec_rs2, dec_use1, dec_use2, ex_rs1, ex_rs2,
               ex_wr_en, ex_wr_reg, ex_ldst_en, br_taken, mem_ready,
        input  stall_f, stall_d, stall_e, bubble_e, flush_d, fwd_a, fwd_b, mem_err
    );

    modport slave (
        input  dec_rs1, dec_rs2, dec_use1, dec_use2, ex_rs1, ex_rs2,
               ex_wr_en, ex_wr_reg, ex_ldst_en, br_taken, mem_ready,
        output stall_f, stall_d, stall_e, bubble_e, flush_d, fwd_a, fwd_b, mem_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow M/W scoreboard, operand forwarding, load-use
// stall, branch flush and memory freeze with a sticky timeout flag.
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t     state_q, state_d;
    logic       m_wr_en_q;
    logic [2:0] m_wr_reg_q;
    logic [1:0] m_ldst_q;
    logic       w_wr_en_q;
    logic [2:0] w_wr_reg_q;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic       m_mem;
    logic       freeze;
    logic       load_use;
    logic       m_fwd_ok;

    assign m_mem    = (m_ldst_q == 2'b01) || (m_ldst_q == 2'b10);
    assign freeze   = m_mem && !hz.mem_ready;
    assign load_use = (hz.ex_ldst_en == 2'b01) && hz.ex_wr_en &&
                      ((hz.dec_use1 && (hz.ex_wr_reg == hz.dec_rs1)) ||
                       (hz.dec_use2 && (hz.ex_wr_reg == hz.dec_rs2)));
    // A load in M has no result yet, so it must never be a forwarding source.
    assign m_fwd_ok = m_wr_en_q && (m_ldst_q != 2'b01);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (freeze)       state_d = ST_WAIT;
            ST_WAIT: if (hz.mem_ready) state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        hz.stall_f  = 1'b0;
        hz.stall_d  = 1'b0;
        hz.stall_e  = 1'b0;
        hz.bubble_e = 1'b0;
        hz.flush_d  = 1'b0;
        if (freeze) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
        end else if (hz.br_taken) begin
            hz.flush_d  = 1'b1;
            hz.bubble_e = 1'b1;
        end else if (load_use) begin
            hz.stall_f  = 1'b1;
            hz.stall_d  = 1'b1;
            hz.bubble_e = 1'b1;
        end
    end

    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (m_fwd_ok && (m_wr_reg_q == hz.ex_rs1)) begin
            hz.fwd_a = 2'b01;
        end else if (w_wr_en_q && (w_wr_reg_q == hz.ex_rs1)) begin
            hz.fwd_a = 2'b10;
        end
        if (m_fwd_ok && (m_wr_reg_q == hz.ex_rs2)) begin
            hz.fwd_b = 2'b01;
        end else if (w_wr_en_q && (w_wr_reg_q == hz.ex_rs2)) begin
            hz.fwd_b = 2'b10;
        end
    end

    // Counter restarts on RUN->WAIT and only advances while still frozen in WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        if ((state_q == ST_RUN) && freeze) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_WAIT) && freeze && (wait_cnt_q != 4'd15)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        if ((state_q == ST_WAIT) && (wait_cnt_d == 4'd15)) begin
            mem_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wr_en_q  <= 1'b0;
            m_wr_reg_q <= '0;
            m_ldst_q   <= '0;
            w_wr_en_q  <= 1'b0;
            w_wr_reg_q <= '0;
        end else if (!freeze) begin
            m_wr_en_q  <= hz.ex_wr_en;
            m_wr_reg_q <= hz.ex_wr_reg;
            m_ldst_q   <= hz.ex_ldst_en;
            w_wr_en_q  <= m_wr_en_q;
            w_wr_reg_q <= m_wr_reg_q;
        end
    end

    assign hz.mem_err = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, freeze, timeout, reset.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    hazard_ctrl_if hif ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packed as {stall_f, stall_d, stall_e, bubble_e, flush_d}.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {3'b000, hif.stall_f, hif.stall_d, hif.stall_e, hif.bubble_e, hif.flush_d},
            {3'b000, exp});
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        chk(tag, {4'b0000, hif.fwd_a, hif.fwd_b}, {4'b0000, ea, eb});
    endtask

    task automatic idle();
        hif.dec_rs1    = '0;
        hif.dec_rs2    = '0;
        hif.dec_use1   = 1'b0;
        hif.dec_use2   = 1'b0;
        hif.ex_rs1     = '0;
        hif.ex_rs2     = '0;
        hif.ex_wr_en   = 1'b0;
        hif.ex_wr_reg  = '0;
        hif.ex_ldst_en = '0;
        hif.br_taken   = 1'b0;
        hif.mem_ready  = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk_ctl("rst_ctl", 5'b00000);
        chk_fwd("rst_fwd", 2'b00, 2'b00);
        chk("rst_err", hif.mem_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Case 1: add r3 then consumer one and two instructions later
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd3; hif.ex_rs1 = 3'd1; hif.ex_rs2 = 3'd2;
        #1 chk_fwd("c1_empty", 2'b00, 2'b00);
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd4; hif.ex_rs1 = 3'd3; hif.ex_rs2 = 3'd5;
        #1 chk_fwd("c1_fwd_m", 2'b01, 2'b00);
        @(negedge clk); idle();
        hif.ex_rs1 = 3'd0; hif.ex_rs2 = 3'd3;
        #1 chk_fwd("c1_fwd_w", 2'b00, 2'b10);
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd6;
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd6;
        @(negedge clk); idle();
        hif.ex_rs1 = 3'd6; hif.ex_rs2 = 3'd6;
        #1 chk_fwd("c1_m_over_w", 2'b01, 2'b01);
        @(negedge clk); idle();
        hif.ex_rs1 = 3'd6;
        #1 chk_fwd("c1_w_only", 2'b10, 2'b00);
        @(negedge clk); idle();

        // Case 2: load r2 in E, Decode reads r2
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd2; hif.ex_ldst_en = 2'b01;
        hif.dec_rs1 = 3'd2; hif.dec_rs2 = 3'd2;
        #1 chk_ctl("c2_no_use", 5'b00000);
        hif.dec_use1 = 1'b1;
        #1 chk_ctl("c2_use1", 5'b11010);
        hif.ex_ldst_en = 2'b10;
        #1 chk_ctl("c2_store_nostall", 5'b00000);
        hif.ex_ldst_en = 2'b01; hif.dec_use1 = 1'b0; hif.dec_use2 = 1'b1;
        #1 chk_ctl("c2_use2", 5'b11010);
        @(negedge clk); idle();
        hif.dec_rs2 = 3'd2; hif.dec_use2 = 1'b1; hif.ex_rs2 = 3'd2;
        #1 chk_ctl("c2_after_bubble", 5'b00000);
        chk_fwd("c2_no_fwd_load_m", 2'b00, 2'b00);
        @(negedge clk); idle();
        hif.ex_rs1 = 3'd2; hif.ex_rs2 = 3'd2;
        #1 chk_fwd("c2_fwd_w", 2'b10, 2'b10);

        // Case 3: branch taken together with load-use
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd5; hif.ex_ldst_en = 2'b01;
        hif.dec_rs1 = 3'd5; hif.dec_use1 = 1'b1; hif.br_taken = 1'b1;
        #1 chk_ctl("c3_branch_wins", 5'b00011);
        @(negedge clk); idle();
        @(negedge clk); idle();

        // Case 4: store in M, mem_ready low for 3 cycles, add r5 in W
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd5;
        @(negedge clk); idle();
        hif.ex_ldst_en = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            hif.mem_ready = 1'b0;
            hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd7; hif.ex_rs1 = 3'd5;
            hif.br_taken = (i == 1);
            #1 chk_ctl("c4_freeze", 5'b11100);
            chk_fwd("c4_hold_fwd", 2'b10, 2'b00);
            chk("c4_err", hif.mem_err, 1'b0);
        end
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd7; hif.ex_rs1 = 3'd5;
        #1 chk_ctl("c4_release", 5'b00000);
        chk_fwd("c4_release_fwd", 2'b10, 2'b00);
        @(negedge clk); idle();
        hif.ex_rs1 = 3'd7; hif.ex_rs2 = 3'd5;
        #1 chk_fwd("c4_advance", 2'b01, 2'b00);
        chk("c4_err_after", hif.mem_err, 1'b0);
        @(negedge clk); idle();
        @(negedge clk); idle();

        // Case 5: load in M, mem_ready low for 20 cycles
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd1; hif.ex_ldst_en = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); idle();
            hif.mem_ready = 1'b0;
            #1 chk("c5_stall_e", hif.stall_e, 1'b1);
            chk($sformatf("c5_err_%0d", i), hif.mem_err, (i >= 17) ? 1'b1 : 1'b0);
        end
        @(negedge clk); idle();
        #1 chk("c5_release", hif.stall_e, 1'b0);
        chk("c5_err_sticky", hif.mem_err, 1'b1);
        @(negedge clk); idle();
        #1 chk("c5_err_sticky2", hif.mem_err, 1'b1);
        #2 rst = 1'b0;
        #1 chk("c5_err_async_clr", hif.mem_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Case 6: reset asserted mid-WAIT
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd4;
        @(negedge clk); idle();
        hif.ex_wr_en = 1'b1; hif.ex_wr_reg = 3'd1; hif.ex_ldst_en = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle();
            hif.mem_ready = 1'b0; hif.ex_rs2 = 3'd4;
            #1 chk_ctl("c6_freeze", 5'b11100);
            chk_fwd("c6_fwd_w", 2'b00, 2'b10);
        end
        #2 rst = 1'b0;
        #1 chk_ctl("c6_async_ctl", 5'b00000);
        chk_fwd("c6_async_fwd", 2'b00, 2'b00);
        chk("c6_async_err", hif.mem_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_ctl("c6_after_rst", 5'b00000);
        @(negedge clk);
        #1 chk_ctl("c6_run", 5'b00000);
        chk_fwd("c6_run_fwd", 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
